// File: rtl/demux_1_3_rr_dispatcher.sv
// Valid/ready distributor: steers each input beat into one of three
// one-entry output buffers, by round-robin pointer or external select.
module demux_1_3_rr_dispatcher #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [1:0]       sel_in,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [1:0]       sel,
    output logic [CNT_W-1:0] beat_cnt
);

    logic [1:0]       ptr;
    logic [WIDTH-1:0] buf_q [3];
    logic [2:0]       free;
    logic             accept;

    always_comb begin
        sel = mode ? sel_in : ptr;
    end

    // A buffer draining this cycle can take a new beat at the same edge.
    assign free = ~out_valid | out_ready;

    always_comb begin
        in_ready = 1'b0;
        case (sel)
            2'd0:    in_ready = free[0];
            2'd1:    in_ready = free[1];
            2'd2:    in_ready = free[2];
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 2'd0;
            out_valid <= 3'b000;
            beat_cnt  <= '0;
            for (int k = 0; k < 3; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (accept && sel == 2'(k)) begin
                    buf_q[k]     <= in_data;
                    out_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept) begin
                beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // Fixed-target mode leaves the round-robin position untouched.
            if (accept && !mode) begin
                ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
            end
        end
    end

    assign dout0 = buf_q[0];
    assign dout1 = buf_q[1];
    assign dout2 = buf_q[2];

endmodule
